// File: rtl/mux_scan_pkg.sv
// Shared definitions for the 4:1 mux scanner: state encoding and channel geometry.
package mux_scan_pkg;

    // FSM state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    // Channel geometry of the scanned mux
    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    // Index of the last channel in a frame
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NCH - 1);

endpackage

// File: rtl/mux_scan_ctrl_dwell_counter.sv
// Dwell counter: counts clock cycles spent on one channel and flags the last one.
// tc is combinational so the capture happens on the same edge the count wraps.
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tc = (count_q == LAST);

    // Next count: hold at zero when cleared, wrap at terminal count, never exceed DWELL-1
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = tc ? '0 : count_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 4:1 mux: steps sel through channels 0..3, holding each for
// DWELL cycles, samples y_in on the last cycle of each dwell and emits the
// reassembled 4-bit frame with a one-cycle valid strobe.
// busy is the FSM state itself (high exactly in SCAN).
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int NCH_P = NCH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             y_in,
    output logic [SEL_W-1:0] sel,
    output logic [NCH-1:0]   data_out,
    output logic             valid,
    output logic             busy
);

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [NCH-1:0]   frame_q, frame_d;
    logic [NCH-1:0]   data_q, data_d;
    logic             valid_q, valid_d;
    logic             tc;

    // Counter runs only while scanning and is held at zero in IDLE, so a scan
    // always starts with a full dwell on channel 0.
    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == ST_IDLE),
        .en    (state_q == ST_SCAN),
        .tc    (tc)
    );

    // Next-state logic: start launches a scan; each terminal count captures one
    // channel; the last channel publishes the frame and consults cont.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        frame_d = frame_q;
        data_d  = data_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sel_d = '0;
                if (start) begin
                    state_d = ST_SCAN;
                    frame_d = '0;
                end
            end
            default: begin
                if (tc) begin
                    frame_d[sel_q] = y_in;
                    if (sel_q != SEL_LAST) begin
                        sel_d = sel_q + SEL_W'(1);
                    end else begin
                        data_d  = {y_in, frame_q[NCH-2:0]};
                        valid_d = 1'b1;
                        sel_d   = '0;
                        frame_d = '0;
                        if (!cont) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
        endcase
    end

    // State and output registers; reset discards any partial frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            frame_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            frame_q <= frame_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign sel      = sel_q;
    assign data_out = data_q;
    assign valid    = valid_q;
    assign busy     = (state_q == ST_SCAN);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: one instance with DWELL=4 and one with DWELL=1.
// Each instance's y_in is a behavioural 4:1 mux over a bench-owned data word.
// Expected frames (value and edge index of the valid strobe) go into a queue
// when a scan is launched; a negedge monitor pops and compares on every valid.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    // DUT A (DWELL=4)
    logic       start_a = 1'b0, cont_a = 1'b0;
    logic [3:0] d_a = 4'b0000;
    logic       y_a;
    logic [1:0] sel_a;
    logic [3:0] data_a;
    logic       valid_a, busy_a;

    // DUT B (DWELL=1)
    logic       start_b = 1'b0, cont_b = 1'b0;
    logic [3:0] d_b = 4'b0000;
    logic       y_b;
    logic [1:0] sel_b;
    logic [3:0] data_b;
    logic       valid_b, busy_b;

    // Expected entries: {edge index of capture, frame}
    logic [35:0] exp_qa[$];
    logic [35:0] exp_qb[$];

    int n_cmp = 0;
    int n_bad = 0;
    logic prev_va = 1'b0, prev_vb = 1'b0;

    assign y_a = d_a[sel_a];
    assign y_b = d_b[sel_b];

    mux_scan_ctrl #(.DWELL(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .cont(cont_a), .y_in(y_a),
        .sel(sel_a), .data_out(data_a), .valid(valid_a), .busy(busy_a)
    );

    mux_scan_ctrl #(.DWELL(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cont(cont_b), .y_in(y_b),
        .sel(sel_b), .data_out(data_b), .valid(valid_b), .busy(busy_b)
    );

    // Clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start; returns the index of the edge that samples it
    task automatic pulse_start_a(output int k);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        start_a = 1'b0;
    endtask

    task automatic pulse_start_b(output int k);
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        start_b = 1'b0;
    endtask

    // Wait for all expected frames to be seen, with a cycle budget
    task automatic drain(input int budget);
        int i;
        for (i = 0; i < budget && (exp_qa.size() != 0 || exp_qb.size() != 0); i++)
            @(negedge clk);
        #1;
        chk("drain_pending", exp_qa.size() + exp_qb.size(), 0);
        exp_qa.delete();
        exp_qb.delete();
    endtask

    // Monitor A
    always @(negedge clk) begin
        logic [35:0] e;
        if (rst) begin
            prev_va = 1'b0;
        end else begin
            if (valid_a) begin
                if (prev_va) flag("a_valid_two_cycles");
                if (exp_qa.size() == 0) begin
                    flag("a_unexpected_valid");
                end else begin
                    e = exp_qa.pop_front();
                    chk("a_data_out", 32'(data_a), 32'(e[3:0]));
                    chk("a_valid_edge", cyc, e[35:4]);
                end
            end
            prev_va = valid_a;
        end
    end

    // Monitor B
    always @(negedge clk) begin
        logic [35:0] e;
        if (rst) begin
            prev_vb = 1'b0;
        end else begin
            if (valid_b) begin
                if (prev_vb) flag("b_valid_two_cycles");
                if (exp_qb.size() == 0) begin
                    flag("b_unexpected_valid");
                end else begin
                    e = exp_qb.pop_front();
                    chk("b_data_out", 32'(data_b), 32'(e[3:0]));
                    chk("b_valid_edge", cyc, e[35:4]);
                end
            end
            prev_vb = valid_b;
        end
    end

    initial begin
        int k;
        // Reset
        rst = 1'b1;
        wait_edges(3);
        chk("rst_sel", 32'(sel_a), 0);
        chk("rst_data", 32'(data_a), 0);
        chk("rst_valid", 32'(valid_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic scan, DWELL=4, D=0110
        d_a = 4'b0110;
        pulse_start_a(k);
        exp_qa.push_back({32'(k + 16), 4'b0110});
        chk("basic_sel_ch0", 32'(sel_a), 0);
        chk("basic_busy", 32'(busy_a), 1);
        wait_edges(4);
        chk("basic_sel_ch1", 32'(sel_a), 1);
        wait_edges(4);
        chk("basic_sel_ch2", 32'(sel_a), 2);
        wait_edges(4);
        chk("basic_sel_ch3", 32'(sel_a), 3);
        drain(40);
        chk("basic_busy_end", 32'(busy_a), 0);
        chk("basic_sel_end", 32'(sel_a), 0);
        chk("basic_data_hold", 32'(data_a), 32'h6);

        // Continuous mode: 1001 then data changes during channel 2 of frame two
        d_a = 4'b1001;
        cont_a = 1'b1;
        pulse_start_a(k);
        exp_qa.push_back({32'(k + 16), 4'b1001});
        exp_qa.push_back({32'(k + 32), 4'b0101});
        wait_edges(16);
        chk("cont_busy_no_gap", 32'(busy_a), 1);
        wait_edges(9);
        chk("cont_sel_ch2", 32'(sel_a), 2);
        d_a = 4'b0101;
        wait_edges(3);
        cont_a = 1'b0;
        drain(40);
        chk("cont_busy_end", 32'(busy_a), 0);

        // Second start mid-scan is ignored
        d_a = 4'b1100;
        pulse_start_a(k);
        exp_qa.push_back({32'(k + 16), 4'b1100});
        wait_edges(4);
        begin
            int k2;
            pulse_start_a(k2);
        end
        wait_edges(1);
        chk("ign_sel_ch1", 32'(sel_a), 1);
        chk("ign_busy", 32'(busy_a), 1);
        drain(40);
        wait_edges(20);
        chk("ign_busy_end", 32'(busy_a), 0);

        // DWELL=1 on instance B
        d_b = 4'b1110;
        pulse_start_b(k);
        exp_qb.push_back({32'(k + 4), 4'b1110});
        chk("d1_sel0", 32'(sel_b), 0);
        wait_edges(1);
        chk("d1_sel1", 32'(sel_b), 1);
        wait_edges(1);
        chk("d1_sel2", 32'(sel_b), 2);
        drain(20);
        chk("d1_busy_end", 32'(busy_b), 0);

        // Reset mid-scan, then a fresh scan
        d_a = 4'b0011;
        pulse_start_a(k);
        exp_qa.push_back({32'(k + 16), 4'b0011});
        wait_edges(8);
        chk("abort_sel_ch2", 32'(sel_a), 2);
        exp_qa.delete();
        rst = 1'b1;
        #1;
        chk("abort_rst_sel", 32'(sel_a), 0);
        chk("abort_rst_data", 32'(data_a), 32'h6 & 32'h0);
        chk("abort_rst_valid", 32'(valid_a), 0);
        chk("abort_rst_busy", 32'(busy_a), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_edges(2);
        d_a = 4'b1011;
        pulse_start_a(k);
        exp_qa.push_back({32'(k + 16), 4'b1011});
        drain(40);
        wait_edges(30);
        chk("final_busy", 32'(busy_a), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
